rs_issue_queue: RTL and testbench
=================================

// Module: rs_issue_queue
// PURPOSE
// Reservation station: holds dispatched uops until both source operands are ready, then issues
// up to ISSUE_WIDTH per cycle. Sits between dispatch and the FU issue registers.
// Uses two psel_gen instances:
// - free-entry allocation: req = ~valid, REQS = DISPATCH_WIDTH
// - ready-entry selection: req = ready, REQS = ISSUE_WIDTH
// PARAMETERS
// SIZE            16  number of RS entries
// DISPATCH_WIDTH   2  uops accepted per cycle
// ISSUE_WIDTH      2  uops issued per cycle
// CDB_WIDTH        2  tag broadcasts per cycle
// TAG_W            6  physical register tag width
// PAYLOAD_W       32  opaque uop payload width
// PORTS
// clock             in   1                     system clock
// reset             in   1                     async active-high reset
// squash            in   1                     flush all entries
// dispatch_valid    in   DISPATCH_WIDTH        lane k carries a uop
// dispatch_payload  in   DISPATCH_WIDTH*PAYLOAD_W  uop payload per lane
// dispatch_dest     in   DISPATCH_WIDTH*TAG_W  destination tag per lane
// dispatch_src1/2   in   DISPATCH_WIDTH*TAG_W  source tags per lane
// dispatch_rdy1/2   in   DISPATCH_WIDTH        source already available
// cdb_valid         in   CDB_WIDTH             broadcast valid
// cdb_tag           in   CDB_WIDTH*TAG_W       broadcast tags
// issue_ready       in   ISSUE_WIDTH           downstream slot i accepts
// issue_valid       out  ISSUE_WIDTH           slot i presents a uop
// issue_payload     out  ISSUE_WIDTH*PAYLOAD_W payload of issued uop
// issue_dest        out  ISSUE_WIDTH*TAG_W     destination tag of issued uop
// free_count        out  $clog2(SIZE+1)        number of empty entries
// BEHAVIOUR
// - Clock and reset: single clock; reset is async active-high.
//   All state (valid, rdy1, rdy2, tags, payload) is cleared on reset.
// - Outputs after reset: issue_valid = 0, free_count = SIZE.
// - free_count: combinational, SIZE - popcount(valid). Reflects current state only.
//   Entries freed this cycle are not counted until the next cycle.
// - Dispatch lanes: must be compacted (valid lanes 0..n-1), with n <= free_count.
// - Dispatch allocation: lane k writes the entry in allocation gnt_bus[k].
//   The entry is valid from the next edge; earliest issue is the following cycle.
// - Dispatch violation: an assertion fires; unallocated lanes are dropped.
// - Wakeup: each not-ready operand compares its tag against every valid cdb_tag.
//   On a match, rdy is set at the edge.
// - Dispatch bypass: a dispatching operand whose tag matches a same-cycle CDB broadcast is
//   written with rdy = 1, so no wakeup is lost.
// - Ready vector: ready[e] = valid[e] & rdy1[e] & rdy2[e], from registered state.
// - Selection: issue slot i takes ready-psel gnt_bus[i].
//   issue_valid[i] = |gnt_bus[i]; payload and dest are muxed out one-hot.
// - Selection priority: psel_gen order (top entry, bottom entry, alternating). No age ordering.
// - Issue outputs: combinational from current state. No hold requirement across cycles.
// - Issue handshake: issue_valid[i] & issue_ready[i] -> entry valid cleared at the edge.
//   If issue_ready[i] = 0, the entry stays and may be reselected next cycle.
// - Freed entries: reallocatable from the next cycle. Dispatch never overwrites an entry
//   that is issuing in the same cycle, because allocation sees only invalid entries.
// - squash: clears every valid bit at the edge. It overrides both dispatch writes and issue
//   clears in that cycle. issue_valid is still driven during the squash cycle; the consumer
//   must ignore it.
// - Reset mid-operation: state clears immediately, asynchronously. issue_valid drops at once.
// - Empty RS: issue_valid = 0. Full RS: free_count = 0; any dispatch_valid is a violation.
// CONFIGURATION
// RS_WAKEUP_BYPASS_EN
// - Defined: the ready vector also ORs in same-cycle CDB matches, so an entry woken in cycle t
//   can issue in cycle t.
// - Undefined (default): a woken entry issues no earlier than t+1. Shorter critical path.
// TESTING
// 1. Reset: free_count = 16, issue_valid = 00. Dispatch 2 ready uops (dest 5, 6)
//    -> next cycle issue_valid = 11 with dests 5 and 6; after accept, free_count = 16.
// 2. Uop src1 = 9 not ready; cdb_tag = 9 broadcast at t -> issue at t+1.
//    With RS_WAKEUP_BYPASS_EN: issue at t.
// 3. Dispatch src1 = 12 in the same cycle cdb broadcasts 12 -> entry issues the next cycle
//    (no lost wakeup).
// 4. Fill all 16 entries -> free_count = 0. Hold issue_ready = 00 for 3 cycles -> same two
//    uops presented each cycle, none lost. Then accept slot 0 only -> free_count = 1.
// 5. 5 ready uops, issue_ready = 11 -> exactly 2 issue per cycle, in psel order. All 5
//    drained in 3 cycles with no duplicate dest.
// 6. squash with a simultaneous dispatch of 2 -> next cycle free_count = 16, issue_valid = 00.

Source files
------------

// File: rtl/rs_issue_queue.sv
// Reservation station: holds dispatched uops until both operands are ready, issues up to ISSUE_WIDTH per cycle.
// Optional RS_WAKEUP_BYPASS_EN lets an entry woken by the CDB issue in that same cycle.

module psel_gen #(
   parameter int WIDTH = 16,
   parameter int REQS  = 2
) (
   input  logic [WIDTH-1:0]      req_i,
   output logic [REQS*WIDTH-1:0] gnt_bus_o
);
   logic [WIDTH-1:0] remaining;
   logic [WIDTH-1:0] sel;

   // Even grants take the highest remaining requester, odd grants the lowest.
   always_comb begin
      remaining = req_i;
      gnt_bus_o = '0;
      sel       = '0;
      for (int k = 0; k < REQS; k++) begin
         sel = '0;
         if ((k % 2) == 0) begin
            for (int e = 0; e < WIDTH; e++)
               if (remaining[e]) begin
                  sel    = '0;
                  sel[e] = 1'b1;
               end
         end else begin
            for (int e = WIDTH - 1; e >= 0; e--)
               if (remaining[e]) begin
                  sel    = '0;
                  sel[e] = 1'b1;
               end
         end
         gnt_bus_o[k*WIDTH +: WIDTH] = sel;
         remaining = remaining & ~sel;
      end
   end
endmodule

module rs_issue_queue #(
   parameter int SIZE           = 16,
   parameter int DISPATCH_WIDTH = 2,
   parameter int ISSUE_WIDTH    = 2,
   parameter int CDB_WIDTH      = 2,
   parameter int TAG_W          = 6,
   parameter int PAYLOAD_W      = 32,
   parameter int CNT_W          = $clog2(SIZE + 1)
) (
   input  logic                                clock_i,
   input  logic                                reset_i,
   input  logic                                squash_i,
   input  logic [DISPATCH_WIDTH-1:0]           dispatch_valid_i,
   input  logic [DISPATCH_WIDTH*PAYLOAD_W-1:0] dispatch_payload_i,
   input  logic [DISPATCH_WIDTH*TAG_W-1:0]     dispatch_dest_i,
   input  logic [DISPATCH_WIDTH*TAG_W-1:0]     dispatch_src1_i,
   input  logic [DISPATCH_WIDTH*TAG_W-1:0]     dispatch_src2_i,
   input  logic [DISPATCH_WIDTH-1:0]           dispatch_rdy1_i,
   input  logic [DISPATCH_WIDTH-1:0]           dispatch_rdy2_i,
   input  logic [CDB_WIDTH-1:0]                cdb_valid_i,
   input  logic [CDB_WIDTH*TAG_W-1:0]          cdb_tag_i,
   input  logic [ISSUE_WIDTH-1:0]              issue_ready_i,
   output logic [ISSUE_WIDTH-1:0]              issue_valid_o,
   output logic [ISSUE_WIDTH*PAYLOAD_W-1:0]    issue_payload_o,
   output logic [ISSUE_WIDTH*TAG_W-1:0]        issue_dest_o,
   output logic [CNT_W-1:0]                    free_count_o
);
   logic [SIZE-1:0]      valid_q, valid_d;
   logic [SIZE-1:0]      rdy1_q, rdy1_d;
   logic [SIZE-1:0]      rdy2_q, rdy2_d;
   logic [TAG_W-1:0]     src1_q [SIZE];
   logic [TAG_W-1:0]     src1_d [SIZE];
   logic [TAG_W-1:0]     src2_q [SIZE];
   logic [TAG_W-1:0]     src2_d [SIZE];
   logic [TAG_W-1:0]     dest_q [SIZE];
   logic [TAG_W-1:0]     dest_d [SIZE];
   logic [PAYLOAD_W-1:0] payload_q [SIZE];
   logic [PAYLOAD_W-1:0] payload_d [SIZE];

   logic [SIZE-1:0]                hit1, hit2, ready;
   logic [DISPATCH_WIDTH-1:0]      dhit1, dhit2;
   logic [DISPATCH_WIDTH*SIZE-1:0] alloc_gnt;
   logic [ISSUE_WIDTH*SIZE-1:0]    issue_gnt;
   logic [CNT_W-1:0]               used_cnt;
   logic [CNT_W-1:0]               disp_cnt;

   always_comb begin
      hit1  = '0;
      hit2  = '0;
      dhit1 = '0;
      dhit2 = '0;
      for (int c = 0; c < CDB_WIDTH; c++) begin
         if (cdb_valid_i[c]) begin
            for (int e = 0; e < SIZE; e++) begin
               if (cdb_tag_i[c*TAG_W +: TAG_W] == src1_q[e]) hit1[e] = 1'b1;
               if (cdb_tag_i[c*TAG_W +: TAG_W] == src2_q[e]) hit2[e] = 1'b1;
            end
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
               if (cdb_tag_i[c*TAG_W +: TAG_W] == dispatch_src1_i[k*TAG_W +: TAG_W]) dhit1[k] = 1'b1;
               if (cdb_tag_i[c*TAG_W +: TAG_W] == dispatch_src2_i[k*TAG_W +: TAG_W]) dhit2[k] = 1'b1;
            end
         end
      end
   end

`ifdef RS_WAKEUP_BYPASS_EN
   assign ready = valid_q & (rdy1_q | hit1) & (rdy2_q | hit2);
`else
   assign ready = valid_q & rdy1_q & rdy2_q;
`endif

   psel_gen #(.WIDTH(SIZE), .REQS(DISPATCH_WIDTH)) u_alloc_sel (
      .req_i     (~valid_q),
      .gnt_bus_o (alloc_gnt)
   );

   psel_gen #(.WIDTH(SIZE), .REQS(ISSUE_WIDTH)) u_issue_sel (
      .req_i     (ready),
      .gnt_bus_o (issue_gnt)
   );

   always_comb begin
      issue_valid_o   = '0;
      issue_payload_o = '0;
      issue_dest_o    = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         issue_valid_o[i] = |issue_gnt[i*SIZE +: SIZE];
         for (int e = 0; e < SIZE; e++) begin
            if (issue_gnt[i*SIZE + e]) begin
               issue_payload_o[i*PAYLOAD_W +: PAYLOAD_W] =
                  issue_payload_o[i*PAYLOAD_W +: PAYLOAD_W] | payload_q[e];
               issue_dest_o[i*TAG_W +: TAG_W] = issue_dest_o[i*TAG_W +: TAG_W] | dest_q[e];
            end
         end
      end
   end

   always_comb begin
      used_cnt = '0;
      for (int e = 0; e < SIZE; e++) used_cnt = used_cnt + CNT_W'(valid_q[e]);
      free_count_o = CNT_W'(SIZE) - used_cnt;
   end

   // Dispatch only lands in invalid entries, so it can never collide with an issuing entry.
   always_comb begin
      valid_d   = valid_q;
      rdy1_d    = rdy1_q | hit1;
      rdy2_d    = rdy2_q | hit2;
      src1_d    = src1_q;
      src2_d    = src2_q;
      dest_d    = dest_q;
      payload_d = payload_q;
      for (int i = 0; i < ISSUE_WIDTH; i++)
         if (issue_valid_o[i] && issue_ready_i[i])
            valid_d = valid_d & ~issue_gnt[i*SIZE +: SIZE];
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
         if (dispatch_valid_i[k]) begin
            for (int e = 0; e < SIZE; e++) begin
               if (alloc_gnt[k*SIZE + e]) begin
                  valid_d[e]   = 1'b1;
                  rdy1_d[e]    = dispatch_rdy1_i[k] | dhit1[k];
                  rdy2_d[e]    = dispatch_rdy2_i[k] | dhit2[k];
                  src1_d[e]    = dispatch_src1_i[k*TAG_W +: TAG_W];
                  src2_d[e]    = dispatch_src2_i[k*TAG_W +: TAG_W];
                  dest_d[e]    = dispatch_dest_i[k*TAG_W +: TAG_W];
                  payload_d[e] = dispatch_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
               end
            end
         end
      end
      if (squash_i) valid_d = '0;
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q <= '0;
         rdy1_q  <= '0;
         rdy2_q  <= '0;
         for (int e = 0; e < SIZE; e++) begin
            src1_q[e]    <= '0;
            src2_q[e]    <= '0;
            dest_q[e]    <= '0;
            payload_q[e] <= '0;
         end
      end else begin
         valid_q   <= valid_d;
         rdy1_q    <= rdy1_d;
         rdy2_q    <= rdy2_d;
         src1_q    <= src1_d;
         src2_q    <= src2_d;
         dest_q    <= dest_d;
         payload_q <= payload_d;
      end
   end

   always_comb begin
      disp_cnt = '0;
      for (int k = 0; k < DISPATCH_WIDTH; k++) disp_cnt = disp_cnt + CNT_W'(dispatch_valid_i[k]);
   end

   // Dispatch lanes must be compacted and must not exceed the free entries.
   dispatch_legal_a : assert property (@(posedge clock_i) disable iff (reset_i)
      (((dispatch_valid_i & (dispatch_valid_i + 1'b1)) == '0) && (disp_cnt <= free_count_o)));
endmodule

// File: tb/tb_rs_issue_queue.sv
// Randomized + directed bench for rs_issue_queue against an entry-array reference model.
module tb_rs_issue_queue;
   localparam int SIZE = 16, DW = 2, IW = 2, CW = 2, TW = 6, PW = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             squash;
   logic [DW-1:0]    d_valid, d_rdy1, d_rdy2;
   logic [DW*PW-1:0] d_pay;
   logic [DW*TW-1:0] d_dest, d_src1, d_src2;
   logic [CW-1:0]    cdb_valid;
   logic [CW*TW-1:0] cdb_tag;
   logic [IW-1:0]    iss_ready, iss_valid;
   logic [IW*PW-1:0] iss_pay;
   logic [IW*TW-1:0] iss_dest;
   logic [4:0]       free_count;

   always #5 clk = ~clk;

   rs_issue_queue dut (
      .clock_i(clk), .reset_i(rst), .squash_i(squash),
      .dispatch_valid_i(d_valid), .dispatch_payload_i(d_pay), .dispatch_dest_i(d_dest),
      .dispatch_src1_i(d_src1), .dispatch_src2_i(d_src2),
      .dispatch_rdy1_i(d_rdy1), .dispatch_rdy2_i(d_rdy2),
      .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .issue_ready_i(iss_ready),
      .issue_valid_o(iss_valid), .issue_payload_o(iss_pay), .issue_dest_o(iss_dest),
      .free_count_o(free_count)
   );

   int vectors = 0, miscompares = 0;

   bit          mv [SIZE], mr1 [SIZE], mr2 [SIZE];
   logic [TW-1:0] ms1 [SIZE], ms2 [SIZE], md [SIZE];
   logic [PW-1:0] mp [SIZE];
   bit          exp_v [IW];
   int          exp_idx [IW];

   function automatic bit cdb_hit(logic [TW-1:0] t);
      for (int c = 0; c < CW; c++)
         if (cdb_valid[c] && cdb_tag[c*TW +: TW] == t) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int model_free();
      int n = 0;
      for (int e = 0; e < SIZE; e++) if (!mv[e]) n++;
      return n;
   endfunction

   task automatic model_reset();
      for (int e = 0; e < SIZE; e++) begin
         mv[e] = 0; mr1[e] = 0; mr2[e] = 0;
      end
   endtask

   // Issue order: highest ready entry to slot 0, lowest remaining ready entry to slot 1.
   task automatic compute_expect();
      int lst [$];
      bit r1, r2;
      for (int e = 0; e < SIZE; e++) begin
         r1 = mr1[e];
         r2 = mr2[e];
`ifdef RS_WAKEUP_BYPASS_EN
         r1 = r1 | cdb_hit(ms1[e]);
         r2 = r2 | cdb_hit(ms2[e]);
`endif
         if (mv[e] && r1 && r2) lst.push_back(e);
      end
      exp_v[0] = lst.size() >= 1;
      exp_v[1] = lst.size() >= 2;
      exp_idx[0] = (lst.size() >= 1) ? lst[lst.size()-1] : 0;
      exp_idx[1] = (lst.size() >= 1) ? lst[0] : 0;
   endtask

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic compare_all();
      compute_expect();
      check("free_count", 64'(free_count), 64'(model_free()));
      for (int i = 0; i < IW; i++) begin
         check($sformatf("issue_valid[%0d]", i), 64'(iss_valid[i]), 64'(exp_v[i]));
         if (exp_v[i] && iss_valid[i]) begin
            check($sformatf("issue_dest[%0d]", i), 64'(iss_dest[i*TW +: TW]), 64'(md[exp_idx[i]]));
            check($sformatf("issue_payload[%0d]", i), 64'(iss_pay[i*PW +: PW]), 64'(mp[exp_idx[i]]));
         end
      end
   endtask

   task automatic model_update();
      int alloc [DW];
      bit taken [SIZE];
      compute_expect();
      for (int e = 0; e < SIZE; e++) taken[e] = mv[e];
      for (int k = 0; k < DW; k++) begin
         alloc[k] = -1;
         if (k % 2 == 0) begin
            for (int e = SIZE - 1; e >= 0 && alloc[k] < 0; e--) if (!taken[e]) alloc[k] = e;
         end else begin
            for (int e = 0; e < SIZE && alloc[k] < 0; e++) if (!taken[e]) alloc[k] = e;
         end
         if (alloc[k] >= 0) taken[alloc[k]] = 1;
      end
      for (int e = 0; e < SIZE; e++) begin
         if (cdb_hit(ms1[e])) mr1[e] = 1;
         if (cdb_hit(ms2[e])) mr2[e] = 1;
      end
      for (int i = 0; i < IW; i++) if (exp_v[i] && iss_ready[i]) mv[exp_idx[i]] = 0;
      for (int k = 0; k < DW; k++) begin
         if (d_valid[k] && alloc[k] >= 0) begin
            mv[alloc[k]]  = 1;
            ms1[alloc[k]] = d_src1[k*TW +: TW];
            ms2[alloc[k]] = d_src2[k*TW +: TW];
            mr1[alloc[k]] = d_rdy1[k] | cdb_hit(d_src1[k*TW +: TW]);
            mr2[alloc[k]] = d_rdy2[k] | cdb_hit(d_src2[k*TW +: TW]);
            md[alloc[k]]  = d_dest[k*TW +: TW];
            mp[alloc[k]]  = d_pay[k*PW +: PW];
         end
      end
      if (squash) for (int e = 0; e < SIZE; e++) mv[e] = 0;
   endtask

   task automatic clear_inputs();
      squash = 0; d_valid = '0; d_rdy1 = '0; d_rdy2 = '0; d_pay = '0;
      d_dest = '0; d_src1 = '0; d_src2 = '0; cdb_valid = '0; cdb_tag = '0;
   endtask

   task automatic set_lane(int k, int dest, int s1, bit r1, int s2, bit r2, logic [PW-1:0] pay);
      d_valid[k] = 1'b1;
      d_dest[k*TW +: TW] = TW'(dest);
      d_src1[k*TW +: TW] = TW'(s1);
      d_src2[k*TW +: TW] = TW'(s2);
      d_rdy1[k] = r1;
      d_rdy2[k] = r2;
      d_pay[k*PW +: PW] = pay;
   endtask

   task automatic settle();
      #1 compare_all();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      iss_ready = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      settle();
      check("reset free_count", 64'(free_count), 64'd16);
      check("reset issue_valid", 64'(iss_valid), 64'd0);

      // two ready uops, dest 5 and 6
      set_lane(0, 5, 1, 1, 2, 1, 32'hA5);
      set_lane(1, 6, 3, 1, 4, 1, 32'hA6);
      iss_ready = 2'b11;
      settle(); tick();
      clear_inputs();
      settle();
      check("t1 issue_valid", 64'(iss_valid), 64'b11);
      check("t1 dest0", 64'(iss_dest[TW-1:0]), 64'd5);
      check("t1 dest1", 64'(iss_dest[2*TW-1:TW]), 64'd6);
      tick(); settle();
      check("t1 free_count", 64'(free_count), 64'd16);

      // wakeup of src1 = 9 via CDB
      set_lane(0, 20, 9, 0, 2, 1, 32'h20);
      settle(); tick();
      clear_inputs();
      cdb_valid = 2'b01; cdb_tag[TW-1:0] = 6'd9;
      settle();
`ifdef RS_WAKEUP_BYPASS_EN
      check("t2 issue at t", 64'(iss_valid), 64'b01);
`else
      check("t2 no issue at t", 64'(iss_valid), 64'b00);
`endif
      tick();
      clear_inputs();
      settle();
`ifdef RS_WAKEUP_BYPASS_EN
      check("t2 drained at t+1", 64'(iss_valid), 64'b00);
`else
      check("t2 issue at t+1", 64'(iss_valid), 64'b01);
`endif
      tick();

      // dispatch-time bypass of tag 12
      set_lane(0, 21, 12, 0, 2, 1, 32'h21);
      cdb_valid = 2'b10; cdb_tag[2*TW-1:TW] = 6'd12;
      settle(); tick();
      clear_inputs();
      settle();
      check("t3 issue_valid", 64'(iss_valid), 64'b01);
      check("t3 dest", 64'(iss_dest[TW-1:0]), 64'd21);
      tick();

      // fill all 16, hold issue_ready = 00
      iss_ready = 2'b00;
      for (int c = 0; c < 8; c++) begin
         set_lane(0, 30 + 2*c, 1, 1, 1, 1, 32'(1000 + 2*c));
         set_lane(1, 31 + 2*c, 1, 1, 1, 1, 32'(1001 + 2*c));
         settle(); tick();
      end
      clear_inputs();
      for (int c = 0; c < 3; c++) begin
         settle();
         check("t4 free_count", 64'(free_count), 64'd0);
         check("t4 hold dest0", 64'(iss_dest[TW-1:0]), 64'd30);
         check("t4 hold dest1", 64'(iss_dest[2*TW-1:TW]), 64'd31);
         tick();
      end
      iss_ready = 2'b01;
      settle(); tick();
      settle();
      check("t4 free_count after slot0", 64'(free_count), 64'd1);
      iss_ready = 2'b11;
      for (int c = 0; c < 10; c++) begin settle(); tick(); end

      // five ready uops drained two per cycle
      iss_ready = 2'b00;
      for (int c = 0; c < 3; c++) begin
         set_lane(0, 40 + 2*c, 1, 1, 1, 1, 32'(40 + 2*c));
         if (c < 2) set_lane(1, 41 + 2*c, 1, 1, 1, 1, 32'(41 + 2*c));
         settle(); tick();
         clear_inputs();
      end
      iss_ready = 2'b11;
      settle();
      check("t5 c0 valid", 64'(iss_valid), 64'b11);
      check("t5 c0 dests", 64'(iss_dest), 64'({6'd41, 6'd40}));
      tick(); settle();
      check("t5 c1 valid", 64'(iss_valid), 64'b11);
      check("t5 c1 dests", 64'(iss_dest), 64'({6'd43, 6'd42}));
      tick(); settle();
      check("t5 c2 valid", 64'(iss_valid), 64'b01);
      check("t5 c2 dest", 64'(iss_dest[TW-1:0]), 64'd44);
      tick(); settle();
      check("t5 empty", 64'(iss_valid), 64'b00);

      // squash overriding dispatch
      set_lane(0, 50, 1, 1, 1, 1, 32'h50);
      set_lane(1, 51, 1, 1, 1, 1, 32'h51);
      squash = 1'b1;
      settle(); tick();
      clear_inputs();
      settle();
      check("t6 free_count", 64'(free_count), 64'd16);
      check("t6 issue_valid", 64'(iss_valid), 64'b00);

      // randomized traffic
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int n, fr;
         clear_inputs();
         fr = model_free();
         n = $urandom_range(0, (fr < 2) ? fr : 2);
         for (int k = 0; k < n; k++)
            set_lane(k, $urandom_range(0, 63), $urandom_range(0, 7), ($urandom_range(0, 9) < 4),
                     $urandom_range(0, 7), ($urandom_range(0, 9) < 4), $urandom);
         for (int c = 0; c < CW; c++) begin
            cdb_valid[c] = $urandom_range(0, 1);
            cdb_tag[c*TW +: TW] = TW'($urandom_range(0, 7));
         end
         iss_ready = IW'($urandom_range(0, 3));
         squash = ($urandom_range(0, 63) == 0);
         settle(); tick();
      end

      // asynchronous reset with ready entries present
      clear_inputs();
      iss_ready = 2'b00;
      set_lane(0, 60, 1, 1, 1, 1, 32'h60);
      settle(); tick();
      clear_inputs();
      settle();
      #2 rst = 1'b1;
      #1;
      check("async rst issue_valid", 64'(iss_valid), 64'b00);
      check("async rst free_count", 64'(free_count), 64'd16);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      settle();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
